commit_unit: RTL

- Retirement stage directly downstream of the ROB.
- Consumes one in-order committed instruction per cycle (pc, inst, rd, value) and writes the architectural register file (ARF).
- Provides two combinational ARF read ports with same-cycle commit bypass to dispatch.
- Counts retired instructions, emits a registered commit trace, detects ECALL/EBREAK halt, and runs a no-progress watchdog.

---
 rtl/commit_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/commit_unit.sv
// Retirement stage: writes the ARF from in-order ROB commits, bypasses reads,
// counts retirements, emits a commit trace, and detects halt or hang.
module commit_unit #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDLE_WIDTH     = 11
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 commit_valid_i,
    input  logic [31:0]          commit_inst_i,
    input  logic [31:0]          commit_pc_i,
    input  logic [4:0]           commit_rd_i,
    input  logic [31:0]          commit_value_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic [31:0]          rs1_data_o,
    output logic [31:0]          rs2_data_o,
    output logic [CNT_WIDTH-1:0] retired_cnt_o,
    output logic                 trace_valid_o,
    output logic [31:0]          trace_pc_o,
    output logic [31:0]          trace_inst_o,
    output logic                 trace_we_o,
    output logic [4:0]           trace_rd_o,
    output logic [31:0]          trace_value_o,
    output logic                 halt_o,
    output logic                 hang_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        HUNG   = 2'd2
    } state_t;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [IDLE_WIDTH-1:0] IDLE_LAST =
        IDLE_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q;
    state_t                state_d;
    logic [IDLE_WIDTH-1:0] idle_q;
    logic [31:0]           arf [32];

    logic       accepted;
    logic       no_write_op;
    logic       we;
    logic       is_halt;
    logic [6:0] opcode;

    assign opcode      = commit_inst_i[6:0];
    assign accepted    = commit_valid_i && (state_q == RUN);
    assign no_write_op = (opcode == OP_STORE) || (opcode == OP_BRANCH)
                      || (opcode == OP_SYSTEM);
    assign we          = accepted && (commit_rd_i != 5'd0) && !no_write_op;
    assign is_halt     = accepted
                      && ((commit_inst_i == ECALL) || (commit_inst_i == EBREAK));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (is_halt) begin
                    state_d = HALTED;
                end else if (!commit_valid_i && (idle_q == IDLE_LAST)) begin
                    state_d = HUNG;
                end
            end
            HALTED:  state_d = HALTED;
            HUNG:    state_d = HUNG;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= RUN;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN) begin
                idle_q <= commit_valid_i ? '0 : idle_q + 1'b1;
            end
        end
    end

    // Entry 0 is cleared on reset and never written, so it always reads 0.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 32; i++) begin
                arf[i] <= '0;
            end
        end else if (we) begin
            arf[commit_rd_i] <= commit_value_i;
        end
    end

    always_comb begin
        rs1_data_o = arf[rs1_addr_i];
        if (rs1_addr_i == 5'd0) begin
            rs1_data_o = '0;
        end else if (we && (rs1_addr_i == commit_rd_i)) begin
            rs1_data_o = commit_value_i;
        end
    end

    always_comb begin
        rs2_data_o = arf[rs2_addr_i];
        if (rs2_addr_i == 5'd0) begin
            rs2_data_o = '0;
        end else if (we && (rs2_addr_i == commit_rd_i)) begin
            rs2_data_o = commit_value_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            retired_cnt_o <= '0;
            trace_valid_o <= 1'b0;
            trace_pc_o    <= '0;
            trace_inst_o  <= '0;
            trace_we_o    <= 1'b0;
            trace_rd_o    <= '0;
            trace_value_o <= '0;
        end else begin
            trace_valid_o <= accepted;
            if (accepted) begin
                retired_cnt_o <= retired_cnt_o + 1'b1;
                trace_pc_o    <= commit_pc_i;
                trace_inst_o  <= commit_inst_i;
                trace_we_o    <= we;
                trace_rd_o    <= commit_rd_i;
                trace_value_o <= commit_value_i;
            end
        end
    end

    assign halt_o = (state_q == HALTED);
    assign hang_o = (state_q == HUNG);

endmodule
